discriminator_dense_layer: RTL and testbench
============================================

DISCRIMINATOR_DENSE_LAYER -- requirements
Module: discriminator_dense_layer

Interface
REQ-001 SHALL have parameter N_IN, default 32, number of inputs per neuron (>=1).
REQ-002 SHALL have parameter N_OUT, default 1, number of output neurons (>=1).
REQ-003 SHALL have parameter DATA_W, default 16, width of inputs, weights, biases and scores; signed fixed point.
REQ-004 SHALL have parameter FRAC, default 8, fractional bits (Q8.8 at defaults).
REQ-005 SHALL have parameter ACC_W, default 40, accumulator width.
REQ-006 SHALL have parameter ACT_MODE, default 0, activation: 0 = identity, 1 = ReLU.
REQ-007 SHALL have parameter THRESH, default 0, signed decision threshold in DATA_W format.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-010 SHALL have port start, input, 1, request to compute one inference.
REQ-011 SHALL have port flat_input_flat, input, DATA_W*N_IN, inputs; element i at bits [(i+1)*DATA_W-1 -: DATA_W].
REQ-012 SHALL have port w_we, input, 1, weight/bias write strobe.
REQ-013 SHALL have port w_addr, input, $clog2(N_OUT*(N_IN+1)), parameter-memory address.
REQ-014 SHALL have port w_data, input, DATA_W, weight or bias value.
REQ-015 SHALL have port busy, output, 1, high from the first edge after start acceptance until done.
REQ-016 SHALL have port score_flat, output, DATA_W*N_OUT, neuron j score at bits [(j+1)*DATA_W-1 -: DATA_W].
REQ-017 SHALL have port decision_flat, output, N_OUT, bit j = score j > THRESH (signed).
REQ-018 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-019 Parameter memory: N_OUT*(N_IN+1) entries; weight i of neuron j at address j*(N_IN+1)+i, bias of neuron j at j*(N_IN+1)+N_IN.
REQ-020 A write at a clock edge with w_we=1, busy=0 and in-range w_addr stores w_data; out-of-range addresses and writes while busy are ignored.
REQ-021 FSM states: IDLE, MAC, WRITE, DONE.
REQ-022 IDLE: start=1 at an edge captures flat_input_flat, clears the accumulator, sets neuron j=0 and input i=0, enters MAC, and sets busy; start in any other state is ignored.
REQ-023 MAC: each edge adds x[i]*w[j][i] (full 2*DATA_W signed product, sign-extended to ACC_W) to the accumulator; after i=N_IN-1, enter WRITE.
REQ-024 WRITE (one edge): r = (acc + (bias<<FRAC) + (1<<(FRAC-1))) >>> FRAC, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], ReLU applied if ACT_MODE=1; writes score j and decision j, clears acc; next neuron's MAC if j<N_OUT-1, else DONE.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start is not accepted in DONE.
REQ-026 Latency: done is high in the cycle beginning N_OUT*(N_IN+1) edges after the start-accepting edge (33 at defaults); next start is accepted one cycle after done.
REQ-027 score_flat and decision_flat hold their values until overwritten by a later WRITE; all neurons are valid and stable while done=1.
REQ-028 A write in the same IDLE edge as an accepted start takes effect before the first MAC read.

Reset
REQ-029 rst_n low, at any time including mid-computation, SHALL immediately force IDLE, busy=0, done=0, score_flat=0, decision_flat=0, accumulator=0, and counters to 0.
REQ-030 Parameter memory SHALL NOT be cleared by reset; contents are retained across reset and undefined until written.

Verification
REQ-031 Defaults, all inputs 0, bias0=0xFE7A -> done at cycle 33, score 0xFE7A, decision 0.
REQ-032 Inputs all 0x0032, weights all 0x0100, bias 0 -> score 0x0640 (1600), decision 1.
REQ-033 Inputs all 0x6400 (100.0), weights 0x0100 -> score 0x7FFF, decision 1; weights 0xFF00 -> 0x8000, decision 0.
REQ-034 N_OUT=2, ACT_MODE=1, neuron0 as REQ-032, neuron1 with weights 0xFF00 -> scores {0x0000, 0x0640}, decisions 2'b01, done at cycle 66.
REQ-035 rst_n low for 1 cycle 10 cycles after start -> busy 0, no done pulse, scores 0; a following start without rewrites reproduces the REQ-032 result.
REQ-036 start and w_we pulsed while busy -> ignored: done occurs once at the original latency and the result is unchanged.

Source files
------------

// File: rtl/discriminator_dense_layer.sv
// -----------------------------------------------------------------------------
// discriminator_dense_layer
//
// Fully-connected layer for a small GAN discriminator. One multiply-accumulate
// is done per clock: every output neuron walks through its N_IN weights, then
// spends one extra cycle adding its bias, rounding, saturating and optionally
// applying ReLU. Weights and biases live in a small parameter memory that the
// host writes while the layer is idle.
//
// Ports
//   clk             : single clock, rising edge
//   rst_n           : asynchronous active-low reset
//   start           : request one inference (honoured only in IDLE)
//   flat_input_flat : N_IN signed inputs, element i at [(i+1)*DATA_W-1 -: DATA_W]
//   w_we            : parameter-memory write strobe (ignored while busy)
//   w_addr          : parameter address, weight i of neuron j at j*(N_IN+1)+i,
//                     bias of neuron j at j*(N_IN+1)+N_IN
//   w_data          : weight or bias value
//   busy            : high while an inference is in flight
//   score_flat      : N_OUT signed scores, neuron j at [(j+1)*DATA_W-1 -: DATA_W]
//   decision_flat   : bit j set when score j > THRESH (signed)
//   done            : one-cycle completion pulse
//
// ACC_W is assumed to be wider than the 2*DATA_W product.
// -----------------------------------------------------------------------------
module discriminator_dense_layer #(
   parameter int N_IN     = 32,
   parameter int N_OUT    = 1,
   parameter int DATA_W   = 16,
   parameter int FRAC     = 8,
   parameter int ACC_W    = 40,
   parameter int ACT_MODE = 0,
   parameter logic signed [DATA_W-1:0] THRESH = '0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [DATA_W*N_IN-1:0]              flat_input_flat,
   input  logic                                w_we,
   input  logic [$clog2(N_OUT*(N_IN+1))-1:0]   w_addr,
   input  logic [DATA_W-1:0]                   w_data,
   output logic                                busy,
   output logic [DATA_W*N_OUT-1:0]             score_flat,
   output logic [N_OUT-1:0]                    decision_flat,
   output logic                                done
);

   localparam int N_PARAM = N_OUT * (N_IN + 1);
   localparam int AW      = $clog2(N_PARAM);
   localparam int IW      = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int JW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int RND_SH  = (FRAC > 0) ? FRAC - 1 : 0;

   localparam logic [AW:0]    PARAM_LIM = (AW+1)'(N_PARAM);
   localparam logic [IW-1:0]  IN_LAST   = IW'(N_IN - 1);
   localparam logic [JW-1:0]  OUT_LAST  = JW'(N_OUT - 1);

   // Rounding constant is half an LSB of the output format, or nothing when
   // there are no fractional bits to drop.
   localparam logic signed [ACC_W:0] ROUND_C =
      (FRAC > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;

   // Saturation bounds of the DATA_W result, expressed in the wide domain.
   localparam logic signed [ACC_W:0] SAT_MAX =
      {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN =
      {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      WRITE,
      DONE
   } state_t;

   state_t                    state_q;
   logic [IW-1:0]             inIdx_q;
   logic [JW-1:0]             neuronIdx_q;
   logic [AW-1:0]             paramAddr_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [DATA_W-1:0]  x_q [N_IN];
   logic signed [DATA_W-1:0]  score_q [N_OUT];
   logic [N_OUT-1:0]          decision_q;
   logic                      busy_q;
   logic                      done_q;

   logic signed [DATA_W-1:0]  paramMem [N_PARAM];

   logic signed [DATA_W-1:0]   xSel;
   logic signed [DATA_W-1:0]   wSel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prodExt;
   logic signed [ACC_W:0]      biased;
   logic signed [ACC_W:0]      shifted;
   logic signed [DATA_W-1:0]   result_d;
   logic                       decision_d;

   // Parameter memory. It is deliberately left out of reset so that a reset in
   // the middle of a run does not force the host to reload every weight.
   // Writes are only taken while the layer is not busy, so a running inference
   // always sees a consistent set of parameters.
   always_ff @(posedge clk) begin
      if (w_we && !busy_q && ({1'b0, w_addr} < PARAM_LIM)) begin
         paramMem[w_addr] <= w_data;
      end
   end

   // Datapath shared by the MAC and WRITE states. In MAC the memory word is a
   // weight; in WRITE the address counter has reached the bias, so the same
   // read port feeds the bias into the rounding adder.
   always_comb begin
      xSel       = x_q[inIdx_q];
      wSel       = paramMem[paramAddr_q];
      prod       = xSel * wSel;
      prodExt    = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      biased     = {acc_q[ACC_W-1], acc_q}
                 + ({{(ACC_W+1-DATA_W){wSel[DATA_W-1]}}, wSel} <<< FRAC)
                 + ROUND_C;
      shifted    = biased >>> FRAC;
      result_d   = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX) begin
         result_d = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         result_d = SAT_MIN[DATA_W-1:0];
      end
      if ((ACT_MODE == 1) && result_d[DATA_W-1]) begin
         result_d = '0;
      end
      decision_d = (result_d > THRESH);
   end

   // Sequencer: IDLE waits for start, MAC steps through one weight per edge,
   // WRITE commits a neuron and moves on, DONE raises the completion pulse for
   // a single cycle. The parameter address runs linearly alongside the input
   // and neuron counters so no multiplier is needed to form it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         inIdx_q     <= '0;
         neuronIdx_q <= '0;
         paramAddr_q <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         decision_q  <= '0;
         for (int i = 0; i < N_IN; i++) begin
            x_q[i] <= '0;
         end
         for (int j = 0; j < N_OUT; j++) begin
            score_q[j] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < N_IN; i++) begin
                     x_q[i] <= flat_input_flat[i*DATA_W +: DATA_W];
                  end
                  acc_q       <= '0;
                  inIdx_q     <= '0;
                  neuronIdx_q <= '0;
                  paramAddr_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= MAC;
               end
            end
            MAC: begin
               acc_q       <= acc_q + prodExt;
               paramAddr_q <= paramAddr_q + AW'(1);
               if (inIdx_q == IN_LAST) begin
                  inIdx_q <= '0;
                  state_q <= WRITE;
               end else begin
                  inIdx_q <= inIdx_q + IW'(1);
               end
            end
            WRITE: begin
               score_q[neuronIdx_q]    <= result_d;
               decision_q[neuronIdx_q] <= decision_d;
               acc_q                   <= '0;
               if (neuronIdx_q == OUT_LAST) begin
                  paramAddr_q <= '0;
                  neuronIdx_q <= '0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  paramAddr_q <= paramAddr_q + AW'(1);
                  neuronIdx_q <= neuronIdx_q + JW'(1);
                  state_q     <= MAC;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_score
      assign score_flat[(j+1)*DATA_W-1 -: DATA_W] = score_q[j];
   end

   assign decision_flat = decision_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_discriminator_dense_layer.sv
// -----------------------------------------------------------------------------
// tb_discriminator_dense_layer
//
// Two layers share one clock, reset, input bus and write data: dutA uses the
// default single-neuron identity configuration, dutB has two neurons with ReLU.
// A behavioural model tracks the parameter memories and predicts busy, done,
// scores and decisions from plain integer arithmetic; directed vectors with
// hand-computed literal results pin the model.
// -----------------------------------------------------------------------------
module tb_discriminator_dense_layer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    start;
   logic [511:0]  flatIn;
   logic [1:0]    we;
   logic [6:0]    wAddr;
   logic [15:0]   wData;

   logic          busyA, doneA, decA;
   logic [15:0]   scoreA;
   logic          busyB, doneB;
   logic [1:0]    decB;
   logic [31:0]   scoreB;

   int assertCnt = 0;
   int failCnt   = 0;
   int edgeCnt   = 0;

   // Model state, one slot per DUT (0 = dutA, 1 = dutB).
   logic signed [15:0] mdlMem [2][66];
   bit                 active [2];
   int                 acceptEdge [2];
   int                 doneEdge [2];
   logic [31:0]        pendScore [2];
   logic [1:0]         pendDec [2];
   logic [31:0]        mdlScore [2];
   logic [1:0]         mdlDec [2];

   always #5 clk = ~clk;

   discriminator_dense_layer #(.N_IN(32), .N_OUT(1), .ACT_MODE(0)) dutA (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .flat_input_flat(flatIn),
      .w_we(we[0]), .w_addr(wAddr[5:0]), .w_data(wData),
      .busy(busyA), .score_flat(scoreA), .decision_flat(decA), .done(doneA)
   );

   discriminator_dense_layer #(.N_IN(32), .N_OUT(2), .ACT_MODE(1)) dutB (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .flat_input_flat(flatIn),
      .w_we(we[1]), .w_addr(wAddr), .w_data(wData),
      .busy(busyB), .score_flat(scoreB), .decision_flat(decB), .done(doneB)
   );

   function automatic int nOut(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   // Expected score of neuron j: dot product, plus bias, round half up,
   // saturate to 16 bits, ReLU on dutB.
   function automatic logic [15:0] neuronScore(int d, int j);
      longint acc;
      longint r;
      acc = 0;
      for (int i = 0; i < 32; i++) begin
         acc += longint'($signed(flatIn[i*16 +: 16])) * longint'(mdlMem[d][j*33+i]);
      end
      r = acc + longint'(mdlMem[d][j*33+32]) * 256 + 128;
      r = r >>> 8;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (d == 1 && r < 0) r = 0;
      return r[15:0];
   endfunction

   task automatic checkOutput(string name, int tag, logic [31:0] act, logic [31:0] exp);
      assertCnt++;
      if (act !== exp) begin
         failCnt++;
         $display("[TB] FAIL %s[%0d]: got %h, expected %h (edge %0d)", name, tag, act, exp, edgeCnt);
      end
   endtask

   // Model update on every rising edge.
   always @(posedge clk) begin
      int a;
      bit blocked;
      logic [15:0] s;
      edgeCnt++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            active[d]   = 1'b0;
            mdlScore[d] = '0;
            mdlDec[d]   = '0;
         end else begin
            a = (d == 0) ? int'(wAddr[5:0]) : int'(wAddr);
            blocked = active[d] && edgeCnt > acceptEdge[d] && edgeCnt <= doneEdge[d];
            if (we[d] && !blocked && a < 33 * nOut(d)) mdlMem[d][a] = wData;
            if (active[d] && edgeCnt == doneEdge[d]) begin
               mdlScore[d] = pendScore[d];
               mdlDec[d]   = pendDec[d];
            end
            if (start[d] && (!active[d] || edgeCnt >= doneEdge[d] + 2)) begin
               active[d]     = 1'b1;
               acceptEdge[d] = edgeCnt;
               doneEdge[d]   = edgeCnt + 33 * nOut(d);
               pendScore[d]  = '0;
               pendDec[d]    = '0;
               for (int j = 0; j < nOut(d); j++) begin
                  s = neuronScore(d, j);
                  pendScore[d][j*16 +: 16] = s;
                  pendDec[d][j] = ($signed(s) > 0);
               end
            end
         end
      end
   end

   // Compare process: busy and done every cycle, results whenever not mid-run.
   always @(negedge clk) begin
      bit expBusy;
      bit expDone;
      if (edgeCnt > 0) begin
         for (int d = 0; d < 2; d++) begin
            expBusy = active[d] && edgeCnt >= acceptEdge[d] && edgeCnt < doneEdge[d];
            expDone = active[d] && edgeCnt == doneEdge[d];
            checkOutput("busy", d, (d == 0) ? busyA : busyB, expBusy);
            checkOutput("done", d, (d == 0) ? doneA : doneB, expDone);
            if (!expBusy) begin
               checkOutput("score", d, (d == 0) ? {16'h0, scoreA} : scoreB, mdlScore[d]);
               checkOutput("decision", d, (d == 0) ? {1'b0, decA} : decB, mdlDec[d]);
            end
         end
      end
   end

   task automatic setInputs(logic [15:0] v);
      for (int i = 0; i < 32; i++) flatIn[i*16 +: 16] = v;
   endtask

   task automatic writeParam(int d, int addr, logic [15:0] v);
      @(negedge clk);
      #2;
      we[d] = 1'b1;
      wAddr = 7'(addr);
      wData = v;
      @(posedge clk);
      #1;
      we[d] = 1'b0;
   endtask

   task automatic loadNeuron(int d, int j, logic [15:0] w, logic [15:0] b);
      for (int i = 0; i < 32; i++) writeParam(d, j*33 + i, w);
      writeParam(d, j*33 + 32, b);
   endtask

   // Pulse start for one edge, optionally with a parameter write on that edge.
   task automatic applyStimulus(int d, bit doWrite, int addr, logic [15:0] v, output int accEdge);
      @(negedge clk);
      #2;
      accEdge  = edgeCnt + 1;
      start[d] = 1'b1;
      if (doWrite) begin
         we[d] = 1'b1;
         wAddr = 7'(addr);
         wData = v;
      end
      @(negedge clk);
      #2;
      start[d] = 1'b0;
      we[d]    = 1'b0;
   endtask

   task automatic waitDone(int d, int limit);
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if ((d == 0) ? doneA : doneB) return;
      end
      checkOutput("doneTimeout", d, 32'd0, 32'd1);
   endtask

   task automatic runAndCheck(int d, string tag, logic [31:0] expScore, logic [1:0] expDec, int expLat);
      int acc;
      applyStimulus(d, 1'b0, 0, 16'h0, acc);
      waitDone(d, 200);
      checkOutput({tag, " latency"}, d, edgeCnt - acc, expLat);
      checkOutput({tag, " score"}, d, (d == 0) ? {16'h0, scoreA} : scoreB, expScore);
      checkOutput({tag, " decision"}, d, (d == 0) ? {1'b0, decA} : decB, expDec);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc;
      int doneSeen;
      rst_n  = 1'b0;
      start  = '0;
      we     = '0;
      wAddr  = '0;
      wData  = '0;
      flatIn = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", 0, busyA, 0);
      checkOutput("resetDone", 0, doneA, 0);
      checkOutput("resetScore", 0, scoreA, 0);
      checkOutput("resetScore", 1, scoreB, 0);
      checkOutput("resetDec", 1, decB, 0);
      #2 rst_n = 1'b1;

      loadNeuron(0, 0, 16'h0100, 16'hFE7A);
      loadNeuron(1, 0, 16'h0100, 16'h0000);
      loadNeuron(1, 1, 16'hFF00, 16'h0000);

      $display("[TB] zero inputs, negative bias");
      runAndCheck(0, "biasOnly", 32'h0000_FE7A, 2'b00, 33);

      $display("[TB] unit weights, inputs 0x0032");
      writeParam(0, 32, 16'h0000);
      setInputs(16'h0032);
      runAndCheck(0, "dot", 32'h0000_0640, 2'b01, 33);

      $display("[TB] two neurons with ReLU");
      runAndCheck(1, "twoNeuron", 32'h0000_0640, 2'b01, 66);

      $display("[TB] saturation");
      setInputs(16'h6400);
      runAndCheck(0, "satPos", 32'h0000_7FFF, 2'b01, 33);
      for (int i = 0; i < 32; i++) writeParam(0, i, 16'hFF00);
      runAndCheck(0, "satNeg", 32'h0000_8000, 2'b00, 33);
      for (int i = 0; i < 32; i++) writeParam(0, i, 16'h0100);
      setInputs(16'h0032);

      $display("[TB] write on the start edge");
      applyStimulus(0, 1'b1, 32, 16'h0001, acc);
      waitDone(0, 200);
      checkOutput("sameEdge latency", 0, edgeCnt - acc, 33);
      checkOutput("sameEdge score", 0, scoreA, 16'h0641);
      writeParam(0, 32, 16'h0000);

      $display("[TB] reset mid-run");
      applyStimulus(0, 1'b0, 0, 16'h0, acc);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midReset busy", 0, busyA, 0);
      checkOutput("midReset score", 0, scoreA, 0);
      checkOutput("midReset score", 1, scoreB, 0);
      #2 rst_n = 1'b1;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (doneA) doneSeen++;
      end
      checkOutput("midReset noDone", 0, doneSeen, 0);
      runAndCheck(0, "afterReset", 32'h0000_0640, 2'b01, 33);

      $display("[TB] start and write while busy, start during done");
      applyStimulus(0, 1'b0, 0, 16'h0, acc);
      repeat (5) @(negedge clk);
      #2;
      start[0] = 1'b1;
      we[0]    = 1'b1;
      wAddr    = 7'd32;
      wData    = 16'h0100;
      @(negedge clk);
      #2;
      start[0] = 1'b0;
      we[0]    = 1'b0;
      waitDone(0, 200);
      checkOutput("busyIgnore latency", 0, edgeCnt - acc, 33);
      checkOutput("busyIgnore score", 0, scoreA, 16'h0640);
      #2 start[0] = 1'b1;
      @(negedge clk);
      #2 start[0] = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("doneStartIgnored busy", 0, busyA, 0);
      runAndCheck(0, "paramsKept", 32'h0000_0640, 2'b01, 33);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
